// File: rtl/kmap_lut.sv
// kmap_lut: runtime-programmable N-input Boolean function unit.
// Holds N_CH truth tables of 2**N_IN bits. Each table is reloaded serially through a
// small config FSM. One input vector per cycle is evaluated across all channels.
// Optional feature: define KMAP_HITCNT_EN to build the per-channel 16-bit hit counters.
module kmap_lut #(
    parameter int          N_IN        = 4,
    parameter int          N_CH        = 1,
    parameter logic [63:0] RESET_TABLE = 64'h0,
    parameter int          CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic                cfg_bit_vld,
    input  logic                cfg_bit,
    input  logic                cfg_abort,
    output logic                cfg_busy,
    output logic                cfg_done,
    input  logic                in_valid,
    input  logic [N_IN-1:0]     in_vec,
    output logic                in_ready,
    output logic                out_valid,
    output logic [N_CH-1:0]     out,
    input  logic                out_ready,
    input  logic                hit_clr,
    output logic [16*N_CH-1:0]  hit_cnt
);

    localparam int              DEPTH    = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } cfgState_e;

    cfgState_e        cfgState_q, cfgState_d;
    logic [CH_W-1:0]  loadCh_q, loadCh_d;
    logic [N_IN-1:0]  bitCnt_q, bitCnt_d;
    logic [DEPTH-1:0] shadow_q, shadow_d;
    logic [DEPTH-1:0] tbl_q [N_CH];
    logic [N_CH-1:0]  out_q;
    logic             outValid_q;
    logic [N_CH-1:0]  evalVec;
    logic             accept;

    // Config FSM next state: IDLE waits for a start, SHIFT collects bits into the shadow
    // register (abort wins over a same-cycle bit), COMMIT lasts exactly one cycle.
    always_comb begin
        cfgState_d = cfgState_q;
        loadCh_d   = loadCh_q;
        bitCnt_d   = bitCnt_q;
        shadow_d   = shadow_q;
        unique case (cfgState_q)
            IDLE: begin
                if (cfg_start) begin
                    cfgState_d = SHIFT;
                    loadCh_d   = cfg_ch;
                    bitCnt_d   = '0;
                end
            end
            SHIFT: begin
                if (cfg_abort) begin
                    cfgState_d = IDLE;
                end else if (cfg_bit_vld) begin
                    shadow_d[bitCnt_q] = cfg_bit;
                    bitCnt_d           = bitCnt_q + 1'b1;
                    if (bitCnt_q == LAST_IDX) begin
                        cfgState_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                cfgState_d = IDLE;
            end
            default: begin
                cfgState_d = IDLE;
            end
        endcase
    end

    // Config FSM registers; a reset mid-load simply throws the partial load away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfgState_q <= IDLE;
            loadCh_q   <= '0;
            bitCnt_q   <= '0;
            shadow_q   <= '0;
        end else begin
            cfgState_q <= cfgState_d;
            loadCh_q   <= loadCh_d;
            bitCnt_q   <= bitCnt_d;
            shadow_q   <= shadow_d;
        end
    end

    assign cfg_busy = (cfgState_q != IDLE);
    assign cfg_done = (cfgState_q == COMMIT);

    // Truth tables: only the selected channel is overwritten in COMMIT; an out-of-range
    // channel number matches no entry, so that commit silently drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                tbl_q[c] <= RESET_TABLE[DEPTH-1:0];
            end
        end else if (cfgState_q == COMMIT) begin
            for (int c = 0; c < N_CH; c++) begin
                if (int'(loadCh_q) == c) begin
                    tbl_q[c] <= shadow_q;
                end
            end
        end
    end

    // Table lookup reads the registered tables, so an eval in the COMMIT cycle sees the old contents.
    always_comb begin
        evalVec = '0;
        for (int c = 0; c < N_CH; c++) begin
            evalVec[c] = tbl_q[c][in_vec];
        end
    end

    assign in_ready = !outValid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Output stage: capture on accept, hold while stalled, drop valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            outValid_q <= 1'b0;
        end else if (accept) begin
            out_q      <= evalVec;
            outValid_q <= 1'b1;
        end else if (out_ready) begin
            outValid_q <= 1'b0;
        end
    end

    assign out       = out_q;
    assign out_valid = outValid_q;

`ifdef KMAP_HITCNT_EN
    logic [15:0] hit_q [N_CH];

    // Saturating per-channel hit counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                hit_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (hit_clr) begin
                    hit_q[c] <= '0;
                end else if (accept && evalVec[c] && (hit_q[c] != 16'hFFFF)) begin
                    hit_q[c] <= hit_q[c] + 16'd1;
                end
            end
        end
    end

    // Pack the counters onto the flat output bus, channel c in slice c.
    always_comb begin
        hit_cnt = '0;
        for (int c = 0; c < N_CH; c++) begin
            hit_cnt[16*c +: 16] = hit_q[c];
        end
    end
`else
    logic unused_hit_clr;
    assign unused_hit_clr = hit_clr;
    assign hit_cnt        = '0;
`endif

endmodule

// File: tb/tb_kmap_lut.sv
// tb_kmap_lut: self-checking bench for kmap_lut (N_IN=4, N_CH=3).
// A negedge monitor keeps a scoreboard of expected eval results; table-driven and
// hand-written sequences cover loading, backpressure, commit collision, abort and reset.
module tb_kmap_lut;

    localparam int          N_IN    = 4;
    localparam int          N_CH    = 3;
    localparam logic [63:0] RST_TBL = 64'h0000_0000_0000_3C5A;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cfg_start;
    logic [1:0]          cfg_ch;
    logic                cfg_bit_vld;
    logic                cfg_bit;
    logic                cfg_abort;
    logic                cfg_busy;
    logic                cfg_done;
    logic                in_valid;
    logic [N_IN-1:0]     in_vec;
    logic                in_ready;
    logic                out_valid;
    logic [N_CH-1:0]     out;
    logic                out_ready;
    logic                hit_clr;
    logic [16*N_CH-1:0]  hit_cnt;

    typedef struct {
        logic [3:0] vec;
        logic       exp0;
    } t2Vec_t;

    t2Vec_t      t2Vecs[16];
    bit          t2List[16];
    int          total = 0;
    int          bad   = 0;
    logic [2:0]  sbQ[$];
    logic [15:0] mdl[N_CH];
    logic [15:0] hitMdl[N_CH];
    logic [2:0]  monExp;
    logic [2:0]  monPop;

    kmap_lut #(
        .N_IN        (N_IN),
        .N_CH        (N_CH),
        .RESET_TABLE (RST_TBL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_start   (cfg_start),
        .cfg_ch      (cfg_ch),
        .cfg_bit_vld (cfg_bit_vld),
        .cfg_bit     (cfg_bit),
        .cfg_abort   (cfg_abort),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .in_valid    (in_valid),
        .in_vec      (in_vec),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out         (out),
        .out_ready   (out_ready),
        .hit_clr     (hit_clr),
        .hit_cnt     (hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] modelEval(input logic [3:0] v);
        logic [2:0] r;
        for (int c = 0; c < N_CH; c++) begin
            r[c] = mdl[c][v];
        end
        return r;
    endfunction

    // Scoreboard: pop and compare whenever a result is consumed, push whenever an input is accepted.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid && out_ready) begin
                if (sbQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL sb_pop: got out=%b expected no result pending at %0t", out, $time);
                end else begin
                    monPop = sbQ.pop_front();
                    checkOutput("sb_out", 64'(out), 64'(monPop));
                end
            end
            monExp = '0;
            if (in_valid && in_ready) begin
                monExp = modelEval(in_vec);
                sbQ.push_back(monExp);
            end
            for (int c = 0; c < N_CH; c++) begin
                if (hit_clr) begin
                    hitMdl[c] = 16'h0;
                end else if (monExp[c] && hitMdl[c] != 16'hFFFF) begin
                    hitMdl[c] = hitMdl[c] + 16'd1;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] v, input logic valid);
        @(posedge clk);
        #1;
        in_valid = valid;
        in_vec   = v;
    endtask

    task automatic sweepAll();
        for (int v = 0; v < 16; v++) begin
            applyStimulus(4'(v), 1'b1);
        end
        applyStimulus(4'd0, 1'b0);
        applyStimulus(4'd0, 1'b0);
    endtask

    task automatic checkHitModel(input string name);
`ifdef KMAP_HITCNT_EN
        for (int c = 0; c < N_CH; c++) begin
            checkOutput(name, 64'(hit_cnt[16*c +: 16]), 64'(hitMdl[c]));
        end
`else
        checkOutput(name, 64'(hit_cnt), 64'h0);
`endif
    endtask

    // Serial load with random evals streamed alongside; a stray cfg_start is thrown in mid-load.
    task automatic loadChannel(input int ch, input logic [15:0] bits, input int nbits,
                               input bit doAbort, input bit evalCommit, input logic [3:0] commitVec);
        bit doneSeen;
        @(posedge clk);
        #1;
        cfg_start = 1'b1;
        cfg_ch    = 2'(ch);
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        checkOutput("busy_shift", 64'(cfg_busy), 64'h1);
        for (int i = 0; i < nbits; i++) begin
            cfg_bit_vld = 1'b1;
            cfg_bit     = bits[i];
            cfg_start   = (i == 3);
            cfg_ch      = 2'(ch ^ 1);
            in_valid    = 1'b1;
            in_vec      = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        cfg_start   = 1'b0;
        cfg_bit_vld = 1'b0;
        in_valid    = 1'b0;
        if (doAbort) begin
            cfg_abort   = 1'b1;
            cfg_bit_vld = 1'b1;
            cfg_bit     = bits[nbits];
            @(posedge clk);
            #1;
            cfg_abort   = 1'b0;
            cfg_bit_vld = 1'b0;
            checkOutput("abort_idle", 64'(cfg_busy), 64'h0);
            doneSeen = cfg_done;
            for (int k = 0; k < 20; k++) begin
                cfg_bit_vld = 1'b1;
                cfg_bit     = 1'b1;
                @(posedge clk);
                #1;
                doneSeen |= cfg_done;
            end
            cfg_bit_vld = 1'b0;
            checkOutput("abort_no_done", 64'(doneSeen), 64'h0);
        end else begin
            checkOutput("done_pulse", 64'(cfg_done), 64'h1);
            checkOutput("busy_commit", 64'(cfg_busy), 64'h1);
            if (evalCommit) begin
                in_valid = 1'b1;
                in_vec   = commitVec;
            end
            @(negedge clk);
            #1;
            if (ch < N_CH) begin
                mdl[ch] = bits;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            checkOutput("done_clear", 64'(cfg_done), 64'h0);
            checkOutput("busy_idle", 64'(cfg_busy), 64'h0);
        end
    endtask

    initial begin
        t2List = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 1, 1, 1};
        for (int i = 0; i < 16; i++) begin
            t2Vecs[i].vec  = 4'(i);
            t2Vecs[i].exp0 = t2List[i];
        end
        for (int c = 0; c < N_CH; c++) begin
            mdl[c]    = RST_TBL[15:0];
            hitMdl[c] = 16'h0;
        end
        rst_n       = 1'b1;
        cfg_start   = 1'b0;
        cfg_ch      = 2'd0;
        cfg_bit_vld = 1'b0;
        cfg_bit     = 1'b0;
        cfg_abort   = 1'b0;
        in_valid    = 1'b0;
        in_vec      = 4'd0;
        out_ready   = 1'b1;
        hit_clr     = 1'b0;

        // T1: asynchronous reset asserted mid-cycle
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_out", 64'(out), 64'h0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'h0);
        checkOutput("rst_busy", 64'(cfg_busy), 64'h0);
        checkOutput("rst_done", 64'(cfg_done), 64'h0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'h1);
        checkOutput("rst_hit", 64'(hit_cnt), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] reset tables sweep");
        sweepAll();

        // T2: load an independent pattern into ch1, then f = ab + cd' into ch0
        loadChannel(1, 16'h8001, 16, 1'b0, 1'b0, 4'd0);
        loadChannel(0, 16'hF444, 16, 1'b0, 1'b0, 4'd0);
        applyStimulus(4'd0, 1'b0);
        hit_clr = 1'b1;
        @(posedge clk);
        #1 hit_clr = 1'b0;

        $display("[TB] table-driven sweep of ch0");
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                applyStimulus(t2Vecs[i].vec, 1'b1);
            end else begin
                applyStimulus(4'd0, 1'b0);
            end
            if (i > 0) begin
                checkOutput("t2_valid", 64'(out_valid), 64'h1);
                checkOutput("t2_out0", 64'(out[0]), 64'(t2Vecs[i-1].exp0));
            end
        end
        applyStimulus(4'd0, 1'b0);
        checkOutput("t2_valid_drop", 64'(out_valid), 64'h0);
        checkOutput("t2_out_kept", 64'(out[0]), 64'h1);

`ifdef KMAP_HITCNT_EN
        // T6: hit counting, saturation and clear priority
        checkOutput("t6_hit7", 64'(hit_cnt[15:0]), 64'h7);
        checkHitModel("t6_hit_model");
        in_valid = 1'b1;
        in_vec   = 4'd15;
        repeat (70000) @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t6_sat", 64'(hit_cnt[15:0]), 64'hFFFF);
        checkHitModel("t6_sat_model");
        hit_clr  = 1'b1;
        in_valid = 1'b1;
        in_vec   = 4'd15;
        @(posedge clk);
        #1;
        hit_clr  = 1'b0;
        in_valid = 1'b0;
        checkOutput("t6_clr_wins", 64'(hit_cnt), 64'h0);
`else
        checkOutput("hit_tied", 64'(hit_cnt), 64'h0);
`endif

        // T3: backpressure on a 12, 2, 5 stream
        $display("[TB] backpressure");
        applyStimulus(4'd12, 1'b1);
        applyStimulus(4'd2, 1'b1);
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("t3_ready_low", 64'(in_ready), 64'h0);
            checkOutput("t3_held", 64'({out_valid, out[0]}), 64'h3);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        checkOutput("t3_ready_rel", 64'(in_ready), 64'h1);
        @(posedge clk);
        #1;
        checkOutput("t3_out_2", 64'(out[0]), 64'h1);
        in_vec = 4'd5;
        @(posedge clk);
        #1;
        checkOutput("t3_out_5", 64'(out[0]), 64'h0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t3_drained", 64'(out_valid), 64'h0);

        // T5: aborted loads leave tables alone; abort beats a same-cycle last bit
        $display("[TB] aborts");
        loadChannel(1, 16'h1234, 7, 1'b1, 1'b0, 4'd0);
        loadChannel(1, 16'hFFFF, 15, 1'b1, 1'b0, 4'd0);
        sweepAll();

        // Out-of-range channel: load completes, commit dropped
        loadChannel(3, 16'hAAAA, 16, 1'b0, 1'b0, 4'd0);
        sweepAll();

        // T4: eval during COMMIT sees the old table, the next eval sees the new one
        $display("[TB] commit collision");
        loadChannel(0, 16'h0000, 16, 1'b0, 1'b0, 4'd0);
        loadChannel(0, 16'hFFFF, 16, 1'b0, 1'b1, 4'd5);
        checkOutput("t4_old_table", 64'(out[0]), 64'h0);
        applyStimulus(4'd5, 1'b1);
        applyStimulus(4'd0, 1'b0);
        checkOutput("t4_new_table", 64'(out[0]), 64'h1);
        sweepAll();

        // Reset mid-load with a result pending
        $display("[TB] reset mid-load");
        @(posedge clk);
        #1;
        cfg_start = 1'b1;
        cfg_ch    = 2'd2;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cfg_bit_vld = 1'b1;
            cfg_bit     = 1'b1;
            in_valid    = 1'b1;
            in_vec      = 4'd15;
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        cfg_bit_vld = 1'b0;
        in_valid    = 1'b0;
        #1;
        checkOutput("mid_rst_out", 64'(out), 64'h0);
        checkOutput("mid_rst_valid", 64'(out_valid), 64'h0);
        checkOutput("mid_rst_busy", 64'(cfg_busy), 64'h0);
        checkOutput("mid_rst_ready", 64'(in_ready), 64'h1);
        checkOutput("mid_rst_hit", 64'(hit_cnt), 64'h0);
        sbQ.delete();
        for (int c = 0; c < N_CH; c++) begin
            mdl[c]    = RST_TBL[15:0];
            hitMdl[c] = 16'h0;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        sweepAll();
        checkOutput("final_busy", 64'(cfg_busy), 64'h0);

        checkHitModel("final_hit_model");
        checkOutput("sb_drain", 64'(sbQ.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
